// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop decoding with a one-byte
// holding register, ready/valid handoff, RTS flow control and error pulses.
module uart_rx #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick_i,
  input  logic       rx_i,
  input  logic       rx_enable_i,
  input  logic       parity_en_i,
  output logic [7:0] rx_d_o,
  output logic       rx_d_valid_o,
  input  logic       rx_d_ready_i,
  output logic       rx_rts_n_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int unsigned TICK_W = 4;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned DATA_W = 8;
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                line;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_en_q, par_en_d;
  logic                par_bad_q, par_bad_d;
  logic                frame_done;
  logic                frame_bad;

  logic [DATA_W-1:0]   rx_d_q, rx_d_d;
  logic                valid_q, valid_d;
  logic                rts_n_q;
  logic                perr_q, perr_d;
  logic                ferr_q;
  logic                ovr_q, ovr_d;
  logic                busy_q;

  assign line = sync_q[SYNC_STAGES-1];

  // Frame decoder: all counting happens only on baud ticks.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bad_d  = par_bad_q;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    if (baud_tick_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_enable_i && !line) begin
            state_d   = S_START;
            tick_d    = '0;
            bit_d     = '0;
            par_en_d  = parity_en_i;
            par_bad_d = 1'b0;
          end
        end
        S_START: begin
          if (tick_q == HALF_LAST) begin
            tick_d  = '0;
            state_d = line ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        S_DATA: begin
          if (tick_q == FULL_LAST) begin
            tick_d  = '0;
            shift_d = {line, shift_q[DATA_W-1:1]};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == LAST_BIT) begin
              state_d = par_en_q ? S_PARITY : S_STOP;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        S_PARITY: begin
          if (tick_q == FULL_LAST) begin
            tick_d    = '0;
            par_bad_d = line ^ (^shift_q);
            state_d   = S_STOP;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        S_STOP: begin
          if (tick_q == FULL_LAST) begin
            tick_d = '0;
            if (line) begin
              frame_done = 1'b1;
              state_d    = S_IDLE;
            end else begin
              frame_bad = 1'b1;
              state_d   = S_BREAK;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        S_BREAK: begin
          if (line) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Holding register: a handshake frees the slot in the same cycle a new byte may land.
  always_comb begin
    rx_d_d  = rx_d_q;
    valid_d = valid_q;
    perr_d  = 1'b0;
    ovr_d   = 1'b0;
    if (valid_q && rx_d_ready_i) begin
      valid_d = 1'b0;
    end
    if (frame_done) begin
      perr_d = par_en_q && par_bad_q;
      if (valid_q && !rx_d_ready_i) begin
        ovr_d = 1'b1;
      end else begin
        rx_d_d  = shift_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '1;
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bad_q <= 1'b0;
      rx_d_q    <= '0;
      valid_q   <= 1'b0;
      rts_n_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bad_q <= par_bad_d;
      rx_d_q    <= rx_d_d;
      valid_q   <= valid_d;
      rts_n_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= frame_bad;
      ovr_q     <= ovr_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign rx_d_o       = rx_d_q;
  assign rx_d_valid_o = valid_q;
  assign rx_rts_n_o   = rts_n_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven bit by bit, results checked against
// an arithmetic frame model (expected bytes, parity/frame/overrun counts).
module tb_uart_rx;

  localparam int unsigned OS       = 16;
  localparam int unsigned TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick = 1'b0;
  logic       rx;
  logic       rx_enable;
  logic       parity_en;
  logic       rx_d_ready;
  logic [7:0] rx_d;
  logic       rx_d_valid;
  logic       rx_rts_n;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int valid_cycles = 0;
  int rts_bad  = 0;
  logic [7:0] acc_q[$];
  int unsigned div = 0;

  uart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .baud_tick_i  (baud_tick),
    .rx_i         (rx),
    .rx_enable_i  (rx_enable),
    .parity_en_i  (parity_en),
    .rx_d_o       (rx_d),
    .rx_d_valid_o (rx_d_valid),
    .rx_d_ready_i (rx_d_ready),
    .rx_rts_n_o   (rx_rts_n),
    .parity_err_o (parity_err),
    .frame_err_o  (frame_err),
    .overrun_o    (overrun),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    baud_tick = (div == TICK_DIV - 1);
    div = (div == TICK_DIV - 1) ? 0 : div + 1;
  end

  // Event recorder; the test tasks compare its deltas against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (parity_err) perr_cnt <= perr_cnt + 1;
      if (frame_err)  ferr_cnt <= ferr_cnt + 1;
      if (overrun)    ovr_cnt  <= ovr_cnt + 1;
      if (rx_d_valid) valid_cycles <= valid_cycles + 1;
      if (rx_d_valid && rx_d_ready) acc_q.push_back(rx_d);
      if (rx_rts_n !== rx_d_valid) rts_bad <= rts_bad + 1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic use_par,
                            input logic par_bit, input logic stop_bit);
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_ticks(OS);
    end
    if (use_par) begin
      rx = par_bit;
      wait_ticks(OS);
    end
    rx = stop_bit;
    wait_ticks(OS);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rx_enable = 1'b1; parity_en = 1'b0; rx_d_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++; if (rx_d !== 8'h00) begin n_fail++; $display("FAIL reset_rx_d: got %h want 00", rx_d); end
    n_checks++; if (rx_d_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rx_d_valid); end
    n_checks++; if (rx_rts_n !== 1'b0) begin n_fail++; $display("FAIL reset_rts_n: got %b want 0", rx_rts_n); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if ({parity_err, frame_err, overrun} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {parity_err, frame_err, overrun});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ticks(8);
  endtask

  task automatic test_8n1();
    int v0, f0;
    acc_q.delete();
    v0 = valid_cycles; f0 = perr_cnt + ferr_cnt + ovr_cnt;
    parity_en = 1'b0; rx_d_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    wait_ticks(2 * OS);
    n_checks++; if (acc_q.size() !== 1) begin n_fail++; $display("FAIL 8n1_count: got %0d want 1", acc_q.size()); end
    else begin
      n_checks++; if (acc_q[0] !== 8'hA5) begin n_fail++; $display("FAIL 8n1_byte: got %h want a5", acc_q[0]); end
    end
    n_checks++; if (valid_cycles - v0 !== 1) begin n_fail++; $display("FAIL 8n1_valid_len: got %0d want 1", valid_cycles - v0); end
    n_checks++; if (perr_cnt + ferr_cnt + ovr_cnt - f0 !== 0) begin
      n_fail++; $display("FAIL 8n1_flags: got %0d want 0", perr_cnt + ferr_cnt + ovr_cnt - f0);
    end
    n_checks++; if (rx_d !== 8'hA5) begin n_fail++; $display("FAIL 8n1_hold: got %h want a5", rx_d); end
  endtask

  task automatic test_parity();
    int p0;
    acc_q.delete();
    p0 = perr_cnt;
    parity_en = 1'b1; rx_d_ready = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    parity_en = 1'b0;
    wait_ticks(2 * OS);
    n_checks++; if (perr_cnt - p0 !== 1) begin n_fail++; $display("FAIL parity_err_count: got %0d want 1", perr_cnt - p0); end
    n_checks++; if (acc_q.size() !== 1 || acc_q[0] !== 8'h3C) begin
      n_fail++; $display("FAIL parity_byte: got %0d bytes, rx_d %h want 1 byte 3c", acc_q.size(), rx_d);
    end
  endtask

  task automatic test_frame_err();
    int fe0, v0;
    fe0 = ferr_cnt; v0 = valid_cycles;
    parity_en = 1'b0;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    wait_ticks(OS);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy: got %b want 1", busy); end
    wait_ticks(2 * OS);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_late: got %b want 1", busy); end
    rx = 1'b1;
    wait_ticks(2 * OS);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break_exit: got %b want 0", busy); end
    n_checks++; if (ferr_cnt - fe0 !== 1) begin n_fail++; $display("FAIL frame_err_count: got %0d want 1", ferr_cnt - fe0); end
    n_checks++; if (valid_cycles - v0 !== 0) begin n_fail++; $display("FAIL frame_err_valid: got %0d want 0", valid_cycles - v0); end
  endtask

  task automatic test_false_start();
    int v0, f0;
    v0 = valid_cycles; f0 = perr_cnt + ferr_cnt + ovr_cnt;
    rx = 1'b0;
    wait_ticks(6);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL false_start_busy: got %b want 1", busy); end
    rx = 1'b1;
    wait_ticks(2 * OS);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL false_start_idle: got %b want 0", busy); end
    n_checks++; if (valid_cycles - v0 !== 0 || perr_cnt + ferr_cnt + ovr_cnt - f0 !== 0) begin
      n_fail++; $display("FAIL false_start_quiet: got valid %0d flags %0d want 0 0",
                         valid_cycles - v0, perr_cnt + ferr_cnt + ovr_cnt - f0);
    end
  endtask

  task automatic test_enable();
    int v0;
    v0 = valid_cycles;
    rx_enable = 1'b0;
    send_frame(8'h77, 1'b0, 1'b0, 1'b1);
    wait_ticks(OS);
    rx_enable = 1'b1;
    wait_ticks(OS);
    n_checks++; if (valid_cycles - v0 !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL enable_block: got valid %0d busy %b want 0 0", valid_cycles - v0, busy);
    end
  endtask

  task automatic test_overrun();
    int o0, r0;
    acc_q.delete();
    o0 = ovr_cnt;
    parity_en = 1'b0; rx_d_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    r0 = rts_bad;
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    wait_ticks(2 * OS);
    n_checks++; if (ovr_cnt - o0 !== 1) begin n_fail++; $display("FAIL overrun_count: got %0d want 1", ovr_cnt - o0); end
    n_checks++; if (rx_d !== 8'h11) begin n_fail++; $display("FAIL overrun_keep: got %h want 11", rx_d); end
    n_checks++; if (rx_rts_n !== 1'b1 || rts_bad - r0 !== 0) begin
      n_fail++; $display("FAIL overrun_rts: got %b (%0d bad cycles) want 1", rx_rts_n, rts_bad - r0);
    end
    rx_d_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rx_d_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", rx_d_valid); end
    n_checks++; if (acc_q.size() !== 1 || acc_q[0] !== 8'h11) begin
      n_fail++; $display("FAIL drain_byte: got %0d bytes want 1 byte 11", acc_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    acc_q.delete();
    parity_en = 1'b0; rx_d_ready = 1'b1;
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      wait_ticks(OS);
    end
    wait_ticks(OS / 2);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (rx_d !== 8'h00 || rx_d_valid !== 1'b0 || rx_rts_n !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midframe_reset: got d %h v %b rts %b busy %b want 00 0 0 0", rx_d, rx_d_valid, rx_rts_n, busy);
    end
    rst = 1'b0;
    wait_ticks(2 * OS);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    wait_ticks(2 * OS);
    n_checks++; if (acc_q.size() !== 1 || rx_d !== 8'h5A) begin
      n_fail++; $display("FAIL after_reset_frame: got %0d bytes rx_d %h want 1 byte 5a", acc_q.size(), rx_d);
    end
  endtask

  // Random frames, some back to back, with random parity mode and parity corruption.
  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic       pe, pbit;
    int         p0, exp_perr;
    acc_q.delete();
    p0 = perr_cnt; exp_perr = 0;
    rx_d_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      b = 8'($urandom_range(0, 255));
      pe = 1'($urandom_range(0, 1));
      pbit = (^b) ^ ($urandom_range(0, 3) == 0);
      parity_en = pe;
      send_frame(b, pe, pbit, 1'b1);
      exp_q.push_back(b);
      if (pe && (pbit != (^b))) exp_perr++;
      if ($urandom_range(0, 1) == 1) wait_ticks(OS);
    end
    parity_en = 1'b0;
    wait_ticks(2 * OS);
    n_checks++; if (acc_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d want %0d", acc_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++; if (acc_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, acc_q[i], exp_q[i]);
        end
      end
    end
    n_checks++; if (perr_cnt - p0 !== exp_perr) begin
      n_fail++; $display("FAIL b2b_parity: got %0d want %0d", perr_cnt - p0, exp_perr);
    end
    n_checks++; if (rts_bad !== 0) begin n_fail++; $display("FAIL rts_tracks_valid: got %0d bad cycles want 0", rts_bad); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_frame_err();
    test_false_start();
    test_enable();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
